range_counter_param: RTL
========================

Name: range_counter_param

Overview:
- Parametrised successor to the fixed 1-to-10 decade counter.
- Counts within a runtime-programmable inclusive window [lo_bound, hi_bound].
- Supports up/down counting, synchronous load with clamping, and three boundary modes: wrap, saturate, bounce.
- Provides a terminal-count output for cascading, a registered wrap/turn pulse, and bound-error detection. Used as the generic timing/sequence counter across the design.

Parameters:
- WIDTH, 4, bit width of count, bounds and load value.
- RST_VAL, 1, count value on reset; must be < 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- en  input  1  count enable
- up_dn  input  1  direction in modes 0/1 (1=up); initial direction on load in mode 2
- mode  input  2  00=wrap, 01=saturate, 10=bounce, 11=treated as wrap
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value to load
- lo_bound  input  WIDTH  inclusive lower bound
- hi_bound  input  WIDTH  inclusive upper bound
- count  output  WIDTH  current count (registered)
- tc  output  1  terminal count (combinational)
- wrap  output  1  one-cycle registered pulse after a wrap or bounce turn
- sat  output  1  level; saturate mode and count held at its bound
- bound_err  output  1  combinational; lo_bound > hi_bound

Behaviour:
- Reset (reset_n=0, asynchronous): count=RST_VAL, wrap=0, internal direction dir_q=up. sat and tc follow from state.
- Release of reset is synchronous to clk; the first count step occurs on the first rising edge with en=1.
- bound_err=1: count, dir_q and wrap hold/clear (wrap=0); en and load ignored.
- Priority per edge: bound_err > load > en. With en=0 and load=0, count holds and wrap is 0 next cycle.
- Load: count <= clamp(load_val): below lo → lo_bound; above hi → hi_bound. dir_q <= up_dn. wrap=0.
- Effective direction d: up_dn in modes 00/01/11; dir_q in mode 10.
- Out of window: if en=1 and count < lo or count > hi (bounds changed at runtime), count <= lo_bound if d=up, else hi_bound. No wrap pulse.
- Normal step (en=1, in window, not at boundary in direction d): count ±1. Arithmetic is WIDTH-bit; no overflow is possible inside the window.
- Up at hi_bound (symmetric for down at lo_bound):
  - wrap mode: count <= lo_bound; wrap=1 next cycle.
  - saturate: count holds; sat=1.
  - bounce: dir_q <= down; count <= hi_bound-1 (holds if lo==hi); wrap=1 next cycle.
- lo_bound == hi_bound:
  - count stays at the bound.
  - Wrap and bounce modes: wrap pulses on every enabled cycle. Saturate mode: sat=1.
- tc = en & ~load & ~bound_err & (count == (d ? hi_bound : lo_bound)). Asserted in the cycle before the wrap/turn/hold edge, for cascading.
- sat = (mode==01) & ~bound_err & (count == (up_dn ? hi_bound : lo_bound)).
- Mode change mid-count takes effect at the next edge. Switching into bounce keeps dir_q from its last load/reset value.
- Reset asserted mid-operation clears immediately, regardless of clk.

Test Plan:
- Reset/wrap up: reset_n=0 → count=1. Release; lo=1, hi=10, mode=00, up, en=1.
  - Expect 1,2,…,10,1.
  - tc=1 while count=10; wrap=1 for exactly one cycle with count=1.
- Down/saturate: mode=01, up_dn=0, load=1 with load_val=3, then en=1.
  - Expect 3,2,1,1,1; sat=1 from count=1; tc=1 at 1; wrap never asserted.
- Bounce: lo=2, hi=5, mode=10, load 2 with up_dn=1, en=1.
  - Expect 2,3,4,5,4,3,2,3.
  - wrap pulses after the 5→4 and 2→3 turns.
- Load clamp and error:
  - load_val=14 with lo=1, hi=10 → count=10.
  - Set lo=8, hi=3 → bound_err=1; count holds 10 despite en=1 and load=1.
- Runtime bounds change: count=9, set hi=6, up, en=1 → next count=lo=1, no wrap pulse.
  - Then en=0 → hold.
  - Assert reset_n=0 mid-cycle → count=1 immediately, wrap=0.

Source files
------------

// File: rtl/range_counter_param.sv
// Runtime-windowed up/down counter with wrap, saturate and bounce boundary modes.
// Provides a cascade terminal count, a registered turn pulse and bound-error detection.
module range_counter_param #(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lo_bound,
  input  logic [WIDTH-1:0] hi_bound,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             bound_err
);

  localparam logic [1:0]       MODE_SAT    = 2'b01;
  localparam logic [1:0]       MODE_BOUNCE = 2'b10;
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_COUNT   = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             dir_r;
  logic             dir_nxt_s;
  logic             wrap_r;
  logic             wrap_nxt_s;
  logic             bound_err_s;
  logic             d_s;
  logic             in_win_s;
  logic             at_edge_s;
  logic             flat_s;
  logic [WIDTH-1:0] edge_val_s;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    logic [WIDTH-1:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign bound_err_s = (lo_bound > hi_bound);
  // Bounce mode follows the stored direction; other modes follow up_dn directly.
  assign d_s         = (mode == MODE_BOUNCE) ? dir_r : up_dn;
  assign edge_val_s  = d_s ? hi_bound : lo_bound;
  assign in_win_s    = (count_r >= lo_bound) && (count_r <= hi_bound);
  assign at_edge_s   = (count_r == edge_val_s);
  assign flat_s      = (lo_bound == hi_bound);

  // Next-state selection: bound error freezes, then load, then counting.
  always_comb begin
    count_nxt_s = count_r;
    dir_nxt_s   = dir_r;
    wrap_nxt_s  = 1'b0;
    if (bound_err_s) begin
      count_nxt_s = count_r;
    end else if (load) begin
      count_nxt_s = clamp(load_val, lo_bound, hi_bound);
      dir_nxt_s   = up_dn;
    end else if (en) begin
      if (!in_win_s) begin
        // Bounds moved under the count: re-enter at the start of the travel direction.
        count_nxt_s = d_s ? lo_bound : hi_bound;
      end else if (at_edge_s) begin
        case (mode)
          MODE_SAT: begin
            count_nxt_s = count_r;
          end
          MODE_BOUNCE: begin
            dir_nxt_s  = ~d_s;
            wrap_nxt_s = 1'b1;
            if (flat_s) begin
              count_nxt_s = count_r;
            end else if (d_s) begin
              count_nxt_s = hi_bound - ONE;
            end else begin
              count_nxt_s = lo_bound + ONE;
            end
          end
          default: begin
            count_nxt_s = d_s ? lo_bound : hi_bound;
            wrap_nxt_s  = 1'b1;
          end
        endcase
      end else if (d_s) begin
        count_nxt_s = count_r + ONE;
      end else begin
        count_nxt_s = count_r - ONE;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= RST_COUNT;
      dir_r   <= 1'b1;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      dir_r   <= dir_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign count     = count_r;
  assign wrap      = wrap_r;
  assign bound_err = bound_err_s;
  assign tc        = en & ~load & ~bound_err_s & at_edge_s;
  assign sat       = (mode == MODE_SAT) & ~bound_err_s &
                     (count_r == (up_dn ? hi_bound : lo_bound));

endmodule
